// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Holds the loader state encoding, the default memory depth and the header width.
package instr_loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam int DEF_MEM_WORDS = 1024;
  localparam int LEN_W         = 16;

endpackage

// File: rtl/instr_mem_loader_byte_packer.sv
// Gathers four accepted bytes into a little-endian 32-bit word.
// The completed word is presented combinationally on the edge-cycle of the fourth byte.
module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_acc,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_done
);

  logic [1:0]  r_cnt;
  logic [31:0] r_word;

  // New bytes enter at the top, so after four shifts the first byte sits in [7:0].
  assign o_word      = {i_byte, r_word[31:8]};
  assign o_word_done = i_acc && (r_cnt == 2'd3);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_word <= '0;
    end else if (i_clr) begin
      r_cnt  <= '0;
      r_word <= '0;
    end else if (i_acc) begin
      r_cnt  <= r_cnt + 2'd1;
      r_word <= o_word;
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Loads a length-prefixed little-endian byte stream into instruction memory.
// Holds the core in reset (busy) while words are written one WE pulse at a time.
module instr_mem_loader
  import instr_loader_pkg::*;
#(
  parameter int          MEM_WORDS = DEF_MEM_WORDS,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        WE,
  output logic [31:0] A,
  output logic [31:0] WD,
  output logic        busy,
  output logic        done,
  output logic        err,
  output state_t      dbg_state
);

  // Byte handshake: a byte moves on a rising edge only when in_valid and in_ready are both 1.
  localparam int IDX_W = $clog2(MEM_WORDS + 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [LEN_W-1:0]   r_count;
  logic [IDX_W-1:0]   r_words;
  logic               r_fin;
  logic               r_we;
  logic [31:0]        r_addr;
  logic [31:0]        r_wd;
  logic               r_done;
  logic               r_err;

  logic               w_active;
  logic               w_acc;
  logic               w_start_ok;
  logic [LEN_W-1:0]   w_len;
  logic               w_len_bad;
  logic               w_pk_acc;
  logic [31:0]        w_word;
  logic               w_word_done;
  logic               w_last_word;

  assign w_active    = (r_state == LEN_LO) || (r_state == LEN_HI) || (r_state == DATA);
  assign w_acc       = in_valid && w_active;
  assign w_start_ok  = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_len       = {in_data, r_count[7:0]};
  assign w_len_bad   = (w_len == '0) || (32'(w_len) > 32'(MEM_WORDS));
  // Bytes offered after the final word, while its WE pulse is out, are dropped.
  assign w_pk_acc    = w_acc && (r_state == DATA) && !r_fin;
  assign w_last_word = ((LEN_W'(r_words) + LEN_W'(1)) == r_count);

  assign in_ready  = w_active;
  assign busy      = w_active;
  assign WE        = r_we;
  assign A         = r_addr;
  assign WD        = r_wd;
  assign done      = r_done;
  assign err       = r_err;
  assign dbg_state = r_state;

  byte_packer u_packer (
    .clk         (clk),
    .rst         (rst),
    .i_clr       (w_start_ok),
    .i_acc       (w_pk_acc),
    .i_byte      (in_data),
    .o_word      (w_word),
    .o_word_done (w_word_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, DONE: if (start) w_state_nxt = LEN_LO;
      LEN_LO:     if (w_acc) w_state_nxt = LEN_HI;
      LEN_HI:     if (w_acc) w_state_nxt = w_len_bad ? DONE : DATA;
      DATA:       if (r_fin) w_state_nxt = DONE;
      default:    w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
      r_words <= '0;
      r_fin   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wd    <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (w_start_ok) begin
        r_done  <= 1'b0;
        r_err   <= 1'b0;
        r_words <= '0;
        r_fin   <= 1'b0;
      end
      if (w_acc && (r_state == LEN_LO)) r_count[7:0] <= in_data;
      if (w_acc && (r_state == LEN_HI)) begin
        r_count[15:8] <= in_data;
        if (w_len_bad) begin
          r_err  <= 1'b1;
          r_done <= 1'b1;
        end
      end
      if ((r_state == DATA) && w_word_done) begin
        r_we    <= 1'b1;
        r_wd    <= w_word;
        r_addr  <= BASE_ADDR + (32'(r_words) << 2);
        r_words <= r_words + IDX_W'(1);
        if (w_last_word) r_fin <= 1'b1;
      end
      // done rises on the edge that ends the final WE pulse.
      if ((r_state == DATA) && r_fin) begin
        r_fin  <= 1'b0;
        r_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: header parsing, word writes, rejects, stalls and reset.
module tb_instr_mem_loader;
  import instr_loader_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        WE;
  logic [31:0] A;
  logic [31:0] WD;
  logic        busy;
  logic        done;
  logic        err;
  state_t      dbg_state;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];

  instr_mem_loader #(.MEM_WORDS(1024), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .WE(WE), .A(A), .WD(WD), .busy(busy), .done(done),
    .err(err), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard: every WE pulse must match the head of the expected queue
  always @(negedge clk) begin
    if (rst && WE) begin
      if (exp_q.size() == 0) check("we_unexpected", {A, WD}, 64'h0);
      else begin
        check("we_word", {A, WD}, exp_q.pop_front());
        check("we_busy", 64'(busy), 64'd1);
      end
    end
  end

  // drivers
  task automatic send_byte(input logic [7:0] b, input logic st);
    int t;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    start    = st;
    t = 0;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check("ready_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      start    = 1'b0;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b0);
  endtask

  task automatic wait_done(input string tag, input logic exp_err);
    int t;
    t = 0;
    while (!done && t < 50) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_err"}, 64'(err), 64'(exp_err));
    check({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    #1;
    check("rst_outs", {29'h0, WE, busy, done, err, in_ready, 27'h0}, 64'h0);
    check("rst_aw", {A, WD}, 64'h0);
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // basic two-word load
    exp_q.push_back({32'h0, 32'h1234_5678});
    exp_q.push_back({32'h4, 32'hDEAD_BEEF});
    pulse_start();
    send_byte(8'h02, 1'b0); send_byte(8'h00, 1'b0);
    send_word(32'h1234_5678); send_word(32'hDEAD_BEEF);
    idle(1);
    wait_done("basic", 1'b0);
    check("basic_hold", {A, WD}, {32'h4, 32'hDEAD_BEEF});

    // count 0 rejected
    pulse_start();
    send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
    idle(1);
    wait_done("cnt0", 1'b1);
    check("cnt0_hold", {A, WD}, {32'h4, 32'hDEAD_BEEF});

    // count 0x0401 rejected
    pulse_start();
    check("restart_clear", {62'h0, done, err}, 64'h0);
    send_byte(8'h01, 1'b0); send_byte(8'h04, 1'b0);
    idle(1);
    wait_done("cnt401", 1'b1);

    // stalled single-word load
    exp_q.push_back({32'h0, 32'h4433_2211});
    pulse_start();
    check("stall_clear", {62'h0, done, err}, 64'h0);
    send_byte(8'h01, 1'b0); send_byte(8'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      send_byte(8'(8'h11 * (i + 1)), 1'b0);
      idle(1);
    end
    wait_done("stall", 1'b0);

    // reset in the middle of a word
    pulse_start();
    send_byte(8'h02, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'hAA, 1'b0); send_byte(8'hBB, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("mid_rst_outs", {59'h0, WE, busy, done, err, in_ready}, 64'h0);
    check("mid_rst_aw", {A, WD}, 64'h0);
    check("mid_rst_state", 64'(dbg_state), 64'(IDLE));
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'h5A;
    end
    idle(1);
    check("post_rst_state", 64'(dbg_state), 64'(IDLE));
    check("post_rst_ready", 64'(in_ready), 64'd0);
    exp_q.push_back({32'h0, 32'hFFEE_DDCC});
    pulse_start();
    send_byte(8'h01, 1'b0); send_byte(8'h00, 1'b0);
    send_word(32'hFFEE_DDCC);
    idle(1);
    wait_done("after_rst", 1'b0);

    // start asserted during DATA is ignored
    exp_q.push_back({32'h0, 32'h0302_0100});
    exp_q.push_back({32'h4, 32'h0706_0504});
    pulse_start();
    send_byte(8'h02, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0); send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1); send_byte(8'h03, 1'b0);
    check("start_ign_state", 64'(dbg_state), 64'(DATA));
    send_word(32'h0706_0504);
    idle(1);
    wait_done("start_ign", 1'b0);

    // full memory
    for (int k = 0; k < 1024; k++) exp_q.push_back({32'(k * 4), 32'hA500_0000 | 32'(k)});
    pulse_start();
    send_byte(8'h00, 1'b0); send_byte(8'h04, 1'b0);
    for (int k = 0; k < 1024; k++) send_word(32'hA500_0000 | 32'(k));
    idle(1);
    wait_done("full", 1'b0);
    check("full_last", {A, WD}, {32'hFFC, 32'hA500_03FF});

    idle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
